// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB master controller:
//   - apb_state_e : 3-bit controller state (IDLE/SETUP/ACCESS)
//   - ADDR_W / DATA_W / SEL_W : default bus widths
//   - apb_req_t   : latched processor request {write, addr, wdata, sel}
//                   at the default widths
// ---------------------------------------------------------------------------
package apb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 2;

  // Unused codes 3..7 are treated as illegal and steer back to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2
  } apb_state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [SEL_W-1:0]  sel;
  } apb_req_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ---------------------------------------------------------------------------
// apb_timeout_cnt
// Counts consecutive ACCESS wait cycles and flags the cycle in which the
// TIMEOUT_CYCLES-th wait is being spent, so the controller can abandon the
// transfer on that edge. Only instantiated when APB_TIMEOUT_EN is defined.
// Ports:
//   clk      in  system clock
//   reset    in  synchronous active-high reset
//   count_en in  1 while in ACCESS with a_ready low; 0 clears the count
//   hit      out wait budget exhausted in the current cycle
// ---------------------------------------------------------------------------
module apb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  output logic hit
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (count_en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q equals the number of waits already spent before this cycle.
  assign hit = count_en && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_master_ctrl.sv
// ---------------------------------------------------------------------------
// apb_master_ctrl
// Single-master APB requester. A one-cycle p_start (with non-zero p_sel)
// in IDLE latches the request and runs one SETUP cycle followed by ACCESS
// until a_ready. Completion returns read data on p_rdata and a one-cycle
// p_stable strobe.
// Optional feature macro: APB_TIMEOUT_EN -- adds the 'timeout' output and
// abandons ACCESS after TIMEOUT_CYCLES wait cycles.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   p_write/p_start       processor request direction and strobe
//   p_addr/p_wdata/p_sel  processor address, write data, slave select
//   p_rdata/p_stable      read data and completion strobe to processor
//   a_reset               registered bus reset to APB slaves
//   a_sel/a_enable/a_write/a_addr/a_wdata  APB PSEL/PENABLE/PWRITE/PADDR/PWDATA
//   a_ready/a_rdata       APB PREADY/PRDATA
//   timeout               (APB_TIMEOUT_EN only) abandoned-transfer flag
// ---------------------------------------------------------------------------
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int ADDR_W         = apb_pkg::ADDR_W,
  parameter int DATA_W         = apb_pkg::DATA_W,
  parameter int SEL_W          = apb_pkg::SEL_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_write,
  input  logic              p_start,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  input  logic [SEL_W-1:0]  p_sel,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_stable,
  output logic              a_reset,
  output logic [SEL_W-1:0]  a_sel,
  output logic              a_enable,
  output logic              a_write,
  output logic [ADDR_W-1:0] a_addr,
  output logic [DATA_W-1:0] a_wdata,
  input  logic              a_ready,
  input  logic [DATA_W-1:0] a_rdata
`ifdef APB_TIMEOUT_EN
  ,
  output logic              timeout
`endif
);

  // Request register sized by this instance's parameters.
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [SEL_W-1:0]  sel;
  } req_t;

  apb_state_e        state_q, state_d;
  req_t              req_q, req_d;
  logic              p_stable_q, p_stable_d;
  logic [DATA_W-1:0] p_rdata_q, p_rdata_d;
  logic              a_reset_q;

`ifdef APB_TIMEOUT_EN
  logic timeout_q, timeout_d;
  logic tmo_hit;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk      (clk),
    .reset    (reset),
    .count_en ((state_q == ST_ACCESS) && !a_ready),
    .hit      (tmo_hit)
  );
`endif

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    p_stable_d = 1'b0;
    p_rdata_d  = p_rdata_q;
`ifdef APB_TIMEOUT_EN
    timeout_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        // A request with no slave selected has nowhere to go; drop it.
        if (p_start && (p_sel != '0)) begin
          req_d   = '{write: p_write, addr: p_addr, wdata: p_wdata, sel: p_sel};
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (a_ready) begin
          if (!req_q.write) begin
            p_rdata_d = a_rdata;
          end
          p_stable_d = 1'b1;
          state_d    = ST_IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else if (tmo_hit) begin
          p_stable_d = 1'b1;
          timeout_d  = 1'b1;
          state_d    = ST_IDLE;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      p_stable_q <= 1'b0;
      p_rdata_q  <= '0;
      a_reset_q  <= 1'b1;
`ifdef APB_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      p_stable_q <= p_stable_d;
      p_rdata_q  <= p_rdata_d;
      a_reset_q  <= 1'b0;
`ifdef APB_TIMEOUT_EN
      timeout_q  <= timeout_d;
`endif
    end
  end

  // Address/data/direction come straight from the request register, so
  // they are stable through SETUP and ACCESS and keep their last values
  // in IDLE. Only PSEL/PENABLE are qualified by state.
  assign a_sel    = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) ? req_q.sel : '0;
  assign a_enable = (state_q == ST_ACCESS);
  assign a_write  = req_q.write;
  assign a_addr   = req_q.addr;
  assign a_wdata  = req_q.wdata;
  assign a_reset  = a_reset_q;
  assign p_stable = p_stable_q;
  assign p_rdata  = p_rdata_q;
`ifdef APB_TIMEOUT_EN
  assign timeout  = timeout_q;
`endif

endmodule

// File: tb/tb_apb_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_apb_master_ctrl
// Directed and randomized transfers against apb_master_ctrl. Expected bus
// behaviour is derived from the transfer rules: one SETUP cycle, then
// (waits+1) ACCESS cycles, then a single completion strobe; p_rdata tracks
// the data of the last completed read.
// ---------------------------------------------------------------------------
module tb_apb_master_ctrl;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int SW  = 2;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          p_write;
  logic          p_start;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  logic [SW-1:0] p_sel;
  logic [DW-1:0] p_rdata;
  logic          p_stable;
  logic          a_reset;
  logic [SW-1:0] a_sel;
  logic          a_enable;
  logic          a_write;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_ready;
  logic [DW-1:0] a_rdata;
`ifdef APB_TIMEOUT_EN
  logic          timeout;
`endif

  apb_master_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .p_write(p_write), .p_start(p_start), .p_addr(p_addr),
    .p_wdata(p_wdata), .p_sel(p_sel),
    .p_rdata(p_rdata), .p_stable(p_stable),
    .a_reset(a_reset), .a_sel(a_sel), .a_enable(a_enable),
    .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rdata(a_rdata)
`ifdef APB_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_rdata;   // model: data of the last completed read

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sel"}, 32'(a_sel), 32'd0);
    chk({tag, "_en"},  32'(a_enable), 32'd0);
    chk({tag, "_stb"}, 32'(p_stable), 32'd0);
  endtask

  // One complete transfer. Returns in the completion cycle (p_stable high),
  // so a following call issues its start back-to-back with the strobe.
  task automatic do_xfer(input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                         input logic [SW-1:0] sl, input int waits, input logic [DW-1:0] rd,
                         input logic poke);
    p_write = w; p_addr = ad; p_wdata = wd; p_sel = sl; p_start = 1'b1;
    a_ready = 1'b0; a_rdata = DW'($urandom);
    step();
    // Scramble the processor side: the bus must use the latched request.
    p_start = 1'b0; p_write = ~w; p_addr = AW'($urandom); p_wdata = DW'($urandom);
    p_sel = SW'($urandom);
    chk("setup_sel",   32'(a_sel), 32'(sl));
    chk("setup_en",    32'(a_enable), 32'd0);
    chk("setup_addr",  32'(a_addr), 32'(ad));
    chk("setup_write", 32'(a_write), 32'(w));
    chk("setup_wdata", 32'(a_wdata), 32'(wd));
    chk("setup_stb",   32'(p_stable), 32'd0);
    chk("setup_arst",  32'(a_reset), 32'd0);
    step();
    for (int i = 0; i <= waits; i++) begin
      a_ready = (i == waits);
      a_rdata = (i == waits) ? rd : DW'($urandom);
      if (poke && i == 0) begin
        p_start = 1'b1; p_sel = 2'd3;
      end else begin
        p_start = 1'b0;
      end
      chk("acc_en",    32'(a_enable), 32'd1);
      chk("acc_sel",   32'(a_sel), 32'(sl));
      chk("acc_addr",  32'(a_addr), 32'(ad));
      chk("acc_write", 32'(a_write), 32'(w));
      chk("acc_wdata", 32'(a_wdata), 32'(wd));
      chk("acc_stb",   32'(p_stable), 32'd0);
`ifdef APB_TIMEOUT_EN
      chk("acc_tmo",   32'(timeout), 32'd0);
`endif
      step();
    end
    p_start = 1'b0; a_ready = 1'b0;
    if (!w) exp_rdata = rd;
    chk("done_stb",   32'(p_stable), 32'd1);
    chk("done_sel",   32'(a_sel), 32'd0);
    chk("done_en",    32'(a_enable), 32'd0);
    chk("done_rdata", 32'(p_rdata), 32'(exp_rdata));
    chk("done_addr",  32'(a_addr), 32'(ad));
    chk("done_wdata", 32'(a_wdata), 32'(wd));
`ifdef APB_TIMEOUT_EN
    chk("done_tmo",   32'(timeout), 32'd0);
`endif
    $display("xfer %s addr=%0h wdata=%0h sel=%0d waits=%0d rdata=%0h poke=%0d",
             w ? "WR" : "RD", ad, wd, sl, waits, p_rdata, poke);
  endtask

  initial begin
    reset = 1'b1; p_write = 1'b0; p_start = 1'b0; p_addr = '0; p_wdata = '0;
    p_sel = '0; a_ready = 1'b0; a_rdata = '0; exp_rdata = '0;
    step(); step();
    chk("rst_arst",  32'(a_reset), 32'd1);
    chk_idle("rst");
    chk("rst_rdata", 32'(p_rdata), 32'd0);
    chk("rst_addr",  32'(a_addr), 32'd0);
    chk("rst_wdata", 32'(a_wdata), 32'd0);
    chk("rst_write", 32'(a_write), 32'd0);
    reset = 1'b0;
    step();
    chk("rel_arst", 32'(a_reset), 32'd0);
    chk_idle("rel");

    // Directed transfers from the test plan.
    do_xfer(1'b1, 8'h00, 8'h05, 2'd1, 0, 8'h00, 1'b0); step(); chk_idle("post_wr0");
    do_xfer(1'b0, 8'h06, 8'h00, 2'd1, 0, 8'h05, 1'b0); step(); chk_idle("post_rd0");
    do_xfer(1'b1, 8'h05, 8'h04, 2'd1, 5, 8'h00, 1'b0); step(); chk_idle("post_wr5");
    do_xfer(1'b0, 8'h07, 8'h00, 2'd1, 5, 8'h06, 1'b0); step(); chk_idle("post_rd5");
    do_xfer(1'b0, 8'h07, 8'h00, 2'd1, 1, 8'h07, 1'b0); step(); chk_idle("post_rd1");
    do_xfer(1'b1, 8'h04, 8'h03, 2'd1, 1, 8'h00, 1'b0); step(); chk_idle("post_wr1");

    // p_start during ACCESS must be ignored.
    do_xfer(1'b1, 8'h09, 8'h22, 2'd2, 2, 8'h00, 1'b1); step(); chk_idle("post_poke");

    // p_start with no slave selected is ignored.
    p_start = 1'b1; p_sel = 2'd0; p_write = 1'b1; p_addr = 8'hAA;
    step();
    p_start = 1'b0;
    chk_idle("nosel1");
    chk("nosel_addr", 32'(a_addr), 32'h09);
    step();
    chk_idle("nosel2");

    // Back-to-back: new start accepted in the strobe cycle.
    do_xfer(1'b0, 8'h31, 8'h00, 2'd3, 0, 8'h5A, 1'b0);
    do_xfer(1'b1, 8'h32, 8'h77, 2'd2, 1, 8'h00, 1'b0);
    step(); chk_idle("post_b2b");

    // Reset while in ACCESS: no strobe, outputs to reset values.
    p_write = 1'b0; p_addr = 8'h44; p_sel = 2'd1; p_start = 1'b1; a_ready = 1'b0;
    step();
    p_start = 1'b0;
    step();
    chk("mid_en", 32'(a_enable), 32'd1);
    reset = 1'b1;
    step();
    exp_rdata = '0;
    chk("mid_arst",  32'(a_reset), 32'd1);
    chk_idle("mid_rst");
    chk("mid_rdata", 32'(p_rdata), 32'd0);
    chk("mid_addr",  32'(a_addr), 32'd0);
    reset = 1'b0;
    step();
    chk("mid_rel_arst", 32'(a_reset), 32'd0);
    chk_idle("mid_rel");
    $display("reset-in-access checked");

    // Randomized transfers.
    for (int n = 0; n < 40; n++) begin
      do_xfer(1'($urandom), AW'($urandom), DW'($urandom), SW'($urandom_range(1, 3)),
              int'($urandom_range(0, 6)), DW'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        step();
        chk_idle("rnd_idle");
      end
    end
    step();
    chk_idle("rnd_end");

`ifdef APB_TIMEOUT_EN
    // Slave never answers: abandon after TMO waits, p_rdata untouched.
    p_write = 1'b0; p_addr = 8'h55; p_sel = 2'd1; p_start = 1'b1; a_ready = 1'b0;
    step();
    p_start = 1'b0;
    step();
    for (int i = 0; i < TMO; i++) begin
      a_rdata = DW'($urandom);
      chk("tmo_en",  32'(a_enable), 32'd1);
      chk("tmo_low", 32'(timeout), 32'd0);
      step();
    end
    chk("tmo_flag",  32'(timeout), 32'd1);
    chk("tmo_stb",   32'(p_stable), 32'd1);
    chk("tmo_rdata", 32'(p_rdata), 32'(exp_rdata));
    chk("tmo_en0",   32'(a_enable), 32'd0);
    step();
    chk("tmo_clr",   32'(timeout), 32'd0);
    chk_idle("tmo_after");
    $display("timeout transfer checked");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
